id_stage: RTL and testbench

Instruction-decode stage of the 5-stage RV32I pipeline. Sits between the IF/ID register (fed by fetch from `ramI`) and the execute stage. It contains the architectural register file, instruction decode, immediate generation and load-use hazard detection, and owns the ID/EX pipeline register. It also drives the debug register read port (`regin`/`regout`) used by the top level.

---
 rtl/id_stage_pkg.sv | 80 ++++++++
 rtl/id_stage_reg_file.sv | 52 +++++
 rtl/id_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_id_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_pkg
// Description : Shared opcodes, ALU / operand-A codes and ID/EX record types
//               for the RV32I decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package id_stage_pkg;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  localparam logic [1:0] c_a_rs1  = 2'd0;
  localparam logic [1:0] c_a_pc   = 2'd1;
  localparam logic [1:0] c_a_zero = 2'd2;

  localparam logic [31:0] c_reset_sp = 32'h1001_03FC;
  localparam logic [31:0] c_reset_gp = 32'h1001_8000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic [1:0] a_sel;
    logic       b_imm;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jal;
    logic       jalr;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    ctrl_t       ctrl;
  } idex_t;

  // 'alt' carries instr[30] where it selects SUB or SRA
  function automatic alu_op_t f_alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32x32 architectural register file, two operand read ports,
//               one debug read port, write-first bypass, x0 hardwired to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
  parameter logic [31:0] RESET_SP = 32'h1001_03FC,
  parameter logic [31:0] RESET_GP = 32'h1001_8000
) (
  input  logic        clockCPU,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_idx1,
  input  logic [4:0]  rd_idx2,
  input  logic [4:0]  dbg_idx,
  output logic [31:0] rd_data1,
  output logic [31:0] rd_data2,
  output logic [31:0] dbg_data
);

  logic [31:0] r_regs [32];

  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      r_regs[2] <= RESET_SP;
      r_regs[3] <= RESET_GP;
    end else if (we && (wr_idx != 5'd0)) begin
      r_regs[wr_idx] <= wr_data;
    end
  end

  // A read of the register being written this cycle sees the new value
  function automatic logic [31:0] f_read(input logic [4:0] idx);
    if (idx == 5'd0)
      return '0;
    else if (we && (wr_idx == idx))
      return wr_data;
    else
      return r_regs[idx];
  endfunction

  assign rd_data1 = f_read(rd_idx1);
  assign rd_data2 = f_read(rd_idx2);
  assign dbg_data = f_read(dbg_idx);

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : RV32I instruction decode: register file, decode, immediate
//               generation, load-use hazard detection and ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_SP = c_reset_sp,
  parameter logic [31:0] RESET_GP = c_reset_gp
) (
  input  logic        clockCPU,
  input  logic        reset,
  input  logic        ifid_valid,
  input  logic [31:0] ifid_pc,
  input  logic [31:0] ifid_instr,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        idex_valid,
  output logic [31:0] idex_pc,
  output logic [31:0] idex_rs1_val,
  output logic [31:0] idex_rs2_val,
  output logic [31:0] idex_imm,
  output logic [4:0]  idex_rs1,
  output logic [4:0]  idex_rs2,
  output logic [4:0]  idex_rd,
  output logic [2:0]  idex_funct3,
  output logic [3:0]  idex_alu_op,
  output logic [1:0]  idex_a_sel,
  output logic        idex_b_imm,
  output logic        idex_regwrite,
  output logic        idex_memread,
  output logic        idex_memwrite,
  output logic        idex_branch,
  output logic        idex_jal,
  output logic        idex_jalr,
  input  logic [4:0]  regin,
  output logic [31:0] regout
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm;
  ctrl_t       w_ctrl;
  logic        w_legal;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_hazard;
  logic        w_stall;
  logic        w_bubble;
  idex_t       w_next;
  idex_t       r_idex;

  assign w_opcode = ifid_instr[6:0];
  assign w_rd     = ifid_instr[11:7];
  assign w_funct3 = ifid_instr[14:12];
  assign w_rs1    = ifid_instr[19:15];
  assign w_rs2    = ifid_instr[24:20];

  reg_file #(
    .RESET_SP (RESET_SP),
    .RESET_GP (RESET_GP)
  ) u_reg_file (
    .clockCPU (clockCPU),
    .reset    (reset),
    .we       (wb_we),
    .wr_idx   (wb_rd),
    .wr_data  (wb_data),
    .rd_idx1  (w_rs1),
    .rd_idx2  (w_rs2),
    .dbg_idx  (regin),
    .rd_data1 (w_rs1_val),
    .rd_data2 (w_rs2_val),
    .dbg_data (regout)
  );

  assign w_imm_i = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
  assign w_imm_s = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
  assign w_imm_b = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                    ifid_instr[30:25], ifid_instr[11:8], 1'b0};
  assign w_imm_u = {ifid_instr[31:12], 12'b0};
  assign w_imm_j = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                    ifid_instr[20], ifid_instr[30:21], 1'b0};

  always_comb begin
    w_ctrl    = '0;
    w_imm     = '0;
    w_legal   = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      c_op_r: begin
        w_legal         = 1'b1;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_ctrl.alu_op   = f_alu_op(w_funct3, ifid_instr[30]);
        w_ctrl.a_sel    = c_a_rs1;
        w_ctrl.regwrite = 1'b1;
      end
      c_op_i: begin
        w_legal         = 1'b1;
        w_use_rs1       = 1'b1;
        w_imm           = w_imm_i;
        // Only SRAI uses instr[30]; for ADDI it is immediate data
        w_ctrl.alu_op   = f_alu_op(w_funct3, (w_funct3 == 3'b101) && ifid_instr[30]);
        w_ctrl.b_imm    = 1'b1;
        w_ctrl.regwrite = 1'b1;
      end
      c_op_load: begin
        w_legal         = 1'b1;
        w_use_rs1       = 1'b1;
        w_imm           = w_imm_i;
        w_ctrl.b_imm    = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memread  = 1'b1;
      end
      c_op_store: begin
        w_legal         = 1'b1;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_imm           = w_imm_s;
        w_ctrl.b_imm    = 1'b1;
        w_ctrl.memwrite = 1'b1;
      end
      c_op_branch: begin
        w_legal         = 1'b1;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_imm           = w_imm_b;
        w_ctrl.alu_op   = ALU_SUB;
        w_ctrl.branch   = 1'b1;
      end
      c_op_jal: begin
        w_legal         = 1'b1;
        w_imm           = w_imm_j;
        w_ctrl.a_sel    = c_a_pc;
        w_ctrl.b_imm    = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.jal      = 1'b1;
      end
      c_op_jalr: begin
        w_legal         = 1'b1;
        w_use_rs1       = 1'b1;
        w_imm           = w_imm_i;
        w_ctrl.a_sel    = c_a_pc;
        w_ctrl.b_imm    = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.jalr     = 1'b1;
      end
      c_op_lui: begin
        w_legal         = 1'b1;
        w_imm           = w_imm_u;
        w_ctrl.a_sel    = c_a_zero;
        w_ctrl.b_imm    = 1'b1;
        w_ctrl.regwrite = 1'b1;
      end
      c_op_auipc: begin
        w_legal         = 1'b1;
        w_imm           = w_imm_u;
        w_ctrl.a_sel    = c_a_pc;
        w_ctrl.b_imm    = 1'b1;
        w_ctrl.regwrite = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Load-use: only source fields the instruction really reads can match
  assign w_hazard = ifid_valid && r_idex.valid && r_idex.ctrl.memread &&
                    (r_idex.rd != 5'd0) &&
                    ((w_use_rs1 && (w_rs1 == r_idex.rd)) ||
                     (w_use_rs2 && (w_rs2 == r_idex.rd)));
  assign w_stall  = w_hazard && !flush;
  assign stall    = w_stall;

  assign w_bubble = flush || w_stall || !ifid_valid || !w_legal;

  always_comb begin
    w_next         = '0;
    w_next.valid   = 1'b1;
    w_next.pc      = ifid_pc;
    w_next.rs1_val = w_rs1_val;
    w_next.rs2_val = w_rs2_val;
    w_next.imm     = w_imm;
    w_next.rs1     = w_rs1;
    w_next.rs2     = w_rs2;
    w_next.rd      = w_rd;
    w_next.funct3  = w_funct3;
    w_next.ctrl    = w_ctrl;
  end

  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset)
      r_idex <= '0;
    else if (w_bubble)
      r_idex <= '0;
    else
      r_idex <= w_next;
  end

  assign idex_valid    = r_idex.valid;
  assign idex_pc       = r_idex.pc;
  assign idex_rs1_val  = r_idex.rs1_val;
  assign idex_rs2_val  = r_idex.rs2_val;
  assign idex_imm      = r_idex.imm;
  assign idex_rs1      = r_idex.rs1;
  assign idex_rs2      = r_idex.rs2;
  assign idex_rd       = r_idex.rd;
  assign idex_funct3   = r_idex.funct3;
  assign idex_alu_op   = r_idex.ctrl.alu_op;
  assign idex_a_sel    = r_idex.ctrl.a_sel;
  assign idex_b_imm    = r_idex.ctrl.b_imm;
  assign idex_regwrite = r_idex.ctrl.regwrite;
  assign idex_memread  = r_idex.ctrl.memread;
  assign idex_memwrite = r_idex.ctrl.memwrite;
  assign idex_branch   = r_idex.ctrl.branch;
  assign idex_jal      = r_idex.ctrl.jal;
  assign idex_jalr     = r_idex.ctrl.jalr;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Directed, scoreboard-checked bench for the RV32I decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jal;
    logic        jalr;
  } exp_t;

  logic        clockCPU = 1'b0;
  logic        reset    = 1'b1;
  logic        ifid_valid = 1'b0;
  logic [31:0] ifid_pc    = '0;
  logic [31:0] ifid_instr = '0;
  logic        flush  = 1'b0;
  logic        wb_we  = 1'b0;
  logic [4:0]  wb_rd  = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  regin  = '0;
  logic        stall;
  logic        idex_valid, idex_b_imm, idex_regwrite, idex_memread, idex_memwrite;
  logic        idex_branch, idex_jal, idex_jalr;
  logic [31:0] idex_pc, idex_rs1_val, idex_rs2_val, idex_imm, regout;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [2:0]  idex_funct3;
  logic [3:0]  idex_alu_op;
  logic [1:0]  idex_a_sel;

  int checks = 0;
  int errors = 0;

  exp_t  sb_exp [$];
  exp_t  sb_msk [$];
  string sb_tag [$];

  localparam logic [31:0] SP = 32'h1001_03FC;
  localparam logic [31:0] GP = 32'h1001_8000;

  localparam logic [31:0] I_ADD_6_5_0  = 32'h0002_8333;
  localparam logic [31:0] I_LW_7_0_2   = 32'h0001_2383;
  localparam logic [31:0] I_ADDI_8_7_1 = 32'h0013_8413;
  localparam logic [31:0] I_LUI_7      = 32'h1234_53B7;
  localparam logic [31:0] I_LUI_9_38   = 32'h0003_84B7;
  localparam logic [31:0] I_ADDI_9_0_7 = 32'h0070_0493;
  localparam logic [31:0] I_BEQ_M8     = 32'hFE00_0CE3;
  localparam logic [31:0] I_BAD        = 32'h0000_007F;
  localparam logic [31:0] I_SW_5_4_2   = 32'h0051_2223;
  localparam logic [31:0] I_SUB_10_6_5 = 32'h4053_0533;
  localparam logic [31:0] I_JAL_1_800  = 32'h0010_00EF;
  localparam logic [31:0] I_AUIPC_11   = 32'h0000_1597;

  id_stage dut (
    .clockCPU      (clockCPU),
    .reset         (reset),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .flush         (flush),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .stall         (stall),
    .idex_valid    (idex_valid),
    .idex_pc       (idex_pc),
    .idex_rs1_val  (idex_rs1_val),
    .idex_rs2_val  (idex_rs2_val),
    .idex_imm      (idex_imm),
    .idex_rs1      (idex_rs1),
    .idex_rs2      (idex_rs2),
    .idex_rd       (idex_rd),
    .idex_funct3   (idex_funct3),
    .idex_alu_op   (idex_alu_op),
    .idex_a_sel    (idex_a_sel),
    .idex_b_imm    (idex_b_imm),
    .idex_regwrite (idex_regwrite),
    .idex_memread  (idex_memread),
    .idex_memwrite (idex_memwrite),
    .idex_branch   (idex_branch),
    .idex_jal      (idex_jal),
    .idex_jalr     (idex_jalr),
    .regin         (regin),
    .regout        (regout)
  );

  always #5 clockCPU = ~clockCPU;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t observed();
    exp_t o;
    o.valid = idex_valid;       o.pc = idex_pc;
    o.rs1_val = idex_rs1_val;   o.rs2_val = idex_rs2_val;
    o.imm = idex_imm;           o.rs1 = idex_rs1;
    o.rs2 = idex_rs2;           o.rd = idex_rd;
    o.funct3 = idex_funct3;     o.alu_op = idex_alu_op;
    o.a_sel = idex_a_sel;       o.b_imm = idex_b_imm;
    o.regwrite = idex_regwrite; o.memread = idex_memread;
    o.memwrite = idex_memwrite; o.branch = idex_branch;
    o.jal = idex_jal;           o.jalr = idex_jalr;
    return o;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, rs1v, rs2v, imm,
                              input logic [4:0] rs1, rs2, rd, input logic [2:0] f3,
                              input logic [3:0] alu, input logic [1:0] asel,
                              input logic bimm, rw, mr, mw, br, jl, jr);
    exp_t e;
    e.valid = 1'b1; e.pc = pc; e.rs1_val = rs1v; e.rs2_val = rs2v; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.funct3 = f3; e.alu_op = alu;
    e.a_sel = asel; e.b_imm = bimm; e.regwrite = rw; e.memread = mr;
    e.memwrite = mw; e.branch = br; e.jal = jl; e.jalr = jr;
    return e;
  endfunction

  // Fields an instruction does not define are excluded from the comparison
  function automatic exp_t mk_mask(input logic use_rs1, use_rs2, use_imm, use_rd);
    exp_t m;
    m = '1;
    if (!use_rs1) begin m.rs1 = '0; m.rs1_val = '0; m.funct3 = '0; end
    if (!use_rs2) begin m.rs2 = '0; m.rs2_val = '0; end
    if (!use_imm) m.imm = '0;
    if (!use_rd)  m.rd  = '0;
    return m;
  endfunction

  function automatic exp_t bubble_mask();
    exp_t m;
    m = '0;
    m.valid = 1'b1; m.alu_op = '1; m.a_sel = '1; m.b_imm = 1'b1;
    m.regwrite = 1'b1; m.memread = 1'b1; m.memwrite = 1'b1;
    m.branch = 1'b1; m.jal = 1'b1; m.jalr = 1'b1;
    return m;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idex(input string tag, input exp_t obs, input exp_t exp, input exp_t msk);
    checks++;
    assert ((obs & msk) === (exp & msk)) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs & msk, exp & msk);
    end
  endtask

  // Drive one ID instruction, check stall, push the expected ID/EX record,
  // then pop and compare once the edge has loaded ID/EX.
  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                      input logic valid, input logic fl, input logic exp_stall,
                      input exp_t e, input exp_t m);
    exp_t  pe, pm;
    string pt;
    ifid_pc = pc; ifid_instr = instr; ifid_valid = valid; flush = fl;
    #1;
    chk32({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
    sb_exp.push_back(e); sb_msk.push_back(m); sb_tag.push_back(tag);
    @(posedge clockCPU);
    #1;
    pe = sb_exp.pop_front(); pm = sb_msk.pop_front(); pt = sb_tag.pop_front();
    chk_idex(pt, observed(), pe, pm);
    flush = 1'b0;
  endtask

  initial begin
    exp_t lw_e;
    exp_t lw_m;
    lw_m = mk_mask(1, 0, 1, 1);

    // Reset state
    #12;
    chk_idex("reset_idex", observed(), '0, '1);
    chk32("reset_stall", {31'd0, stall}, 32'd0);
    regin = 5'd2; #1; chk32("reset_x2", regout, SP);
    regin = 5'd3; #1; chk32("reset_x3", regout, GP);
    regin = 5'd0; #1; chk32("reset_x0", regout, 32'd0);
    @(posedge clockCPU); #1;
    reset = 1'b0;

    // WB write to x5 bypassed into ID read in the same cycle
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; regin = 5'd5;
    #1; chk32("dbg_bypass_x5", regout, 32'hDEAD_BEEF);
    step("add_bypass", 32'h100, I_ADD_6_5_0, 1, 0, 0,
         mk(32'h100, 32'hDEAD_BEEF, 0, 0, 5, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),
         mk_mask(1, 1, 0, 1));
    wb_we = 1'b0; wb_data = '0;
    #1; chk32("dbg_stored_x5", regout, 32'hDEAD_BEEF);

    // Load followed by dependent addi: one bubble, then the addi
    lw_e = mk(32'h104, SP, 0, 0, 2, 0, 7, 3'd2, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    step("lw_a", 32'h104, I_LW_7_0_2, 1, 0, 0, lw_e, lw_m);
    step("loaduse_bubble", 32'h108, I_ADDI_8_7_1, 1, 0, 1, '0, bubble_mask());
    step("addi_after_bubble", 32'h108, I_ADDI_8_7_1, 1, 0, 0,
         mk(32'h108, 0, 0, 1, 7, 0, 8, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0),
         mk_mask(1, 0, 1, 1));

    // LUI never reads rs1/rs2, even when those bit fields match the load rd
    lw_e.pc = 32'h10C;
    step("lw_b", 32'h10C, I_LW_7_0_2, 1, 0, 0, lw_e, lw_m);
    step("lui_x7", 32'h110, I_LUI_7, 1, 0, 0,
         mk(32'h110, 0, 0, 32'h1234_5000, 0, 0, 7, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0),
         mk_mask(0, 0, 1, 1));
    lw_e.pc = 32'h114;
    step("lw_c", 32'h114, I_LW_7_0_2, 1, 0, 0, lw_e, lw_m);
    step("lui_rs1field_7", 32'h118, I_LUI_9_38, 1, 0, 0,
         mk(32'h118, 0, 0, 32'h0003_8000, 0, 0, 9, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0),
         mk_mask(0, 0, 1, 1));
    lw_e.pc = 32'h11C;
    step("lw_d", 32'h11C, I_LW_7_0_2, 1, 0, 0, lw_e, lw_m);
    step("addi_rs2field_7", 32'h120, I_ADDI_9_0_7, 1, 0, 0,
         mk(32'h120, 0, 0, 32'd7, 0, 0, 9, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0),
         mk_mask(1, 0, 1, 1));

    // Flush wins over a load-use hazard
    lw_e.pc = 32'h124;
    step("lw_e", 32'h124, I_LW_7_0_2, 1, 0, 0, lw_e, lw_m);
    step("flush_bubble", 32'h128, I_ADDI_8_7_1, 1, 1, 0, '0, bubble_mask());

    // Branch immediate, illegal opcode, invalid IF/ID
    begin
      exp_t bm;
      bm = mk_mask(1, 1, 1, 0);
      bm.alu_op = '0;
      step("beq_m8", 32'h128, I_BEQ_M8, 1, 0, 0,
           mk(32'h128, 0, 0, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), bm);
    end
    step("bad_opcode", 32'h12C, I_BAD, 1, 0, 0, '0, bubble_mask());
    step("ifid_invalid", 32'h130, I_ADD_6_5_0, 0, 0, 0, '0, bubble_mask());

    // Store, SUB, JAL, AUIPC
    step("sw", 32'h130, I_SW_5_4_2, 1, 0, 0,
         mk(32'h130, SP, 32'hDEAD_BEEF, 32'd4, 2, 5, 0, 3'd2, 0, 0, 1, 0, 0, 1, 0, 0, 0),
         mk_mask(1, 1, 1, 0));
    step("sub", 32'h134, I_SUB_10_6_5, 1, 0, 0,
         mk(32'h134, 0, 32'hDEAD_BEEF, 0, 6, 5, 10, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0),
         mk_mask(1, 1, 0, 1));
    begin
      exp_t jm;
      jm = mk_mask(0, 0, 1, 1);
      jm.b_imm = 1'b0;
      step("jal", 32'h138, I_JAL_1_800, 1, 0, 0,
           mk(32'h138, 0, 0, 32'h0000_0800, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0), jm);
    end
    step("auipc", 32'h13C, I_AUIPC_11, 1, 0, 0,
         mk(32'h13C, 0, 0, 32'h0000_1000, 0, 0, 11, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0),
         mk_mask(0, 0, 1, 1));

    // Asynchronous reset in the middle of a stall
    lw_e.pc = 32'h140;
    step("lw_f", 32'h140, I_LW_7_0_2, 1, 0, 0, lw_e, lw_m);
    ifid_pc = 32'h144; ifid_instr = I_ADDI_8_7_1; ifid_valid = 1'b1;
    #1; chk32("prereset_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk32("midreset_stall", {31'd0, stall}, 32'd0);
    chk_idex("midreset_idex", observed(), '0, '1);
    regin = 5'd5; #1; chk32("midreset_x5", regout, 32'd0);
    regin = 5'd2; #1; chk32("midreset_x2", regout, SP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
